// File: rtl/sw_input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_input_pkg
// Description : Shared constants for the switch/pushbutton input controller:
//               FSM state encodings, gp_in bit positions, default timings.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_input_pkg;

    localparam int DEF_DEB_CYCLES    = 25;
    localparam int DEF_REPEAT_CYCLES = 2500;

    localparam int GPI_N_LSB = 0;
    localparam int GPI_SEL   = 4;
    localparam int GPI_PEND  = 5;

    localparam int         c_STATE_W    = 2;
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESSED      = 2'd1;
    localparam logic [1:0] RELEASE_WAIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/debounce_cell.sv
`default_nettype none
// ============================================================================
// Module      : debounce_cell
// Description : 2-flop synchronizer followed by a stable-count debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_cell
    import sw_input_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_deb
);

    localparam int c_CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_deb;
    logic [c_CNT_W-1:0] r_cnt;

    // The accept edge is the one seen while the count already sits at its
    // last value, giving 2 + DEB_CYCLES edges from a clean raw change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb = r_deb;

endmodule
`default_nettype wire

// File: rtl/sw_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sw_input_ctrl
// Description : Debounced operand/select switches and go button; snapshots
//               the switches on each press into a registered GPIO word.
//               Optional auto-repeat while held: define PB_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_input_ctrl
    import sw_input_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw_n,
    input  logic        sw_sel,
    input  logic        pb_go,
    input  logic        ack,
    output logic [31:0] gp_in,
    output logic        go_pulse,
    output logic        pending
);

    logic [5:0]           w_raw;
    logic [5:0]           w_deb;
    logic [3:0]           w_deb_n;
    logic                 w_deb_sel;
    logic                 w_deb_pb;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic                 w_press;
    logic                 w_rpt_evt;
    logic                 w_evt;

    logic [3:0]           r_snap_n;
    logic                 r_snap_sel;
    logic                 r_pending;
    logic [31:0]          r_gp_in;
    logic [3:0]           w_snap_n_nxt;
    logic                 w_snap_sel_nxt;
    logic                 w_pend_nxt;
    logic [31:0]          w_gp_nxt;

    assign w_raw = {pb_go, sw_sel, sw_n};

    generate
        for (genvar i = 0; i < 6; i++) begin : g_deb
            debounce_cell #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk   (clk),
                .rst   (rst),
                .i_raw (w_raw[i]),
                .o_deb (w_deb[i])
            );
        end
    endgenerate

    assign w_deb_n   = w_deb[3:0];
    assign w_deb_sel = w_deb[4];
    assign w_deb_pb  = w_deb[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A high debounced button in IDLE is always a fresh rising edge: it can
    // only be high there after a reset-cleared or freshly fallen level.
    always_comb begin
        w_state_nxt = r_state;
        w_press     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_deb_pb) begin
                    w_state_nxt = PRESSED;
                    w_press     = 1'b1;
                end
            end
            PRESSED: begin
                if (!w_deb_pb) begin
                    w_state_nxt = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef PB_AUTOREPEAT_EN
    localparam int c_RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [c_RPT_W-1:0] c_RPT_LAST = c_RPT_W'(REPEAT_CYCLES - 1);

    logic [c_RPT_W-1:0] r_rpt_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rpt_cnt <= '0;
        end else if (r_state != PRESSED) begin
            r_rpt_cnt <= '0;
        end else if (r_rpt_cnt == c_RPT_LAST) begin
            r_rpt_cnt <= '0;
        end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
        end
    end

    assign w_rpt_evt = (r_state == PRESSED) && w_deb_pb && (r_rpt_cnt == c_RPT_LAST);
`else
    // Constant zero; the parameter is referenced only to keep it visible.
    assign w_rpt_evt = 1'b0 & (REPEAT_CYCLES > 0);
`endif

    assign w_evt = w_press | w_rpt_evt;

    // A press event outranks a simultaneous ack.
    always_comb begin
        w_snap_n_nxt   = r_snap_n;
        w_snap_sel_nxt = r_snap_sel;
        w_pend_nxt     = r_pending;
        if (w_evt) begin
            w_snap_n_nxt   = w_deb_n;
            w_snap_sel_nxt = w_deb_sel;
            w_pend_nxt     = 1'b1;
        end else if (ack) begin
            w_pend_nxt = 1'b0;
        end
        w_gp_nxt                   = '0;
        w_gp_nxt[GPI_N_LSB +: 4]   = w_snap_n_nxt;
        w_gp_nxt[GPI_SEL]          = w_snap_sel_nxt;
        w_gp_nxt[GPI_PEND]         = w_pend_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_n   <= '0;
            r_snap_sel <= 1'b0;
            r_pending  <= 1'b0;
            r_gp_in    <= '0;
        end else begin
            r_snap_n   <= w_snap_n_nxt;
            r_snap_sel <= w_snap_sel_nxt;
            r_pending  <= w_pend_nxt;
            r_gp_in    <= w_gp_nxt;
        end
    end

    assign go_pulse = w_evt;
    assign pending  = r_pending;
    assign gp_in    = r_gp_in;

endmodule
`default_nettype wire

// File: tb/tb_sw_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_input_ctrl
// Description : Directed self-checking bench for sw_input_ctrl
//               (DEB_CYCLES=4, REPEAT_CYCLES=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_input_ctrl;

`ifdef PB_AUTOREPEAT_EN
    localparam bit c_AR = 1'b1;
`else
    localparam bit c_AR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw_n;
    logic        sw_sel;
    logic        pb_go;
    logic        ack;
    logic [31:0] gp_in;
    logic        go_pulse;
    logic        pending;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    int p0;

    sw_input_ctrl #(
        .DEB_CYCLES    (4),
        .REPEAT_CYCLES (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_n     (sw_n),
        .sw_sel   (sw_sel),
        .pb_go    (pb_go),
        .ack      (ack),
        .gp_in    (gp_in),
        .go_pulse (go_pulse),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (go_pulse) n_pulses <= n_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raw press at the current slot; go_pulse must appear on the 6th edge.
    task automatic press_and_check(input string tag);
        pb_go = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check({tag, "_early"}, 32'(go_pulse), 32'd0);
        end
        tick(1);
        check({tag, "_go"}, 32'(go_pulse), 32'd1);
    endtask

    initial begin
        rst = 1'b1; sw_n = 4'h0; sw_sel = 1'b0; pb_go = 1'b0; ack = 1'b0;
        tick(3);
        check("rst_gp",   gp_in, 32'h0);
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_go",   32'(go_pulse), 32'd0);
        rst = 1'b0;

        // Basic press: n=5, sel=1
        sw_n = 4'h5; sw_sel = 1'b1;
        tick(8);
        check("pre_gp", gp_in, 32'h0);
        press_and_check("p1");
        tick(1);
        check("p1_single", 32'(go_pulse), 32'd0);
        check("p1_gp",   gp_in, 32'h35);
        check("p1_pend", 32'(pending), 32'd1);
        pb_go = 1'b0;
        tick(10);

        // Short glitches on the button
        p0 = n_pulses;
        pb_go = 1'b1; tick(2); pb_go = 1'b0; tick(2);
        pb_go = 1'b1; tick(2); pb_go = 1'b0; tick(12);
        check("glitch_pulses", 32'(n_pulses - p0), 32'd0);
        check("glitch_gp", gp_in, 32'h35);

        // ack clears pending only
        ack = 1'b1; tick(1); ack = 1'b0;
        check("ack_gp",   gp_in, 32'h15);
        check("ack_pend", 32'(pending), 32'd0);

        // Switch change without press
        sw_n = 4'h3;
        tick(10);
        check("noprs_gp", gp_in, 32'h15);

        // Press coinciding with ack, n=A
        sw_n = 4'hA;
        tick(8);
        press_and_check("p2");
        ack = 1'b1; tick(1); ack = 1'b0;
        check("p2_gp",   gp_in, 32'h3A);
        check("p2_pend", 32'(pending), 32'd1);
        pb_go = 1'b0;
        tick(10);

        // Press while still pending, n=C sel=0
        sw_n = 4'hC; sw_sel = 1'b0;
        tick(8);
        press_and_check("p3");
        tick(1);
        check("p3_gp",   gp_in, 32'h2C);
        check("p3_pend", 32'(pending), 32'd1);
        pb_go = 1'b0;
        tick(10);

        // Reset two cycles into a press debounce
        p0 = n_pulses;
        pb_go = 1'b1;
        tick(2);
        rst = 1'b1;
        #1;
        check("arst_gp",   gp_in, 32'h0);
        check("arst_pend", 32'(pending), 32'd0);
        pb_go = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(12);
        check("abort_pulses", 32'(n_pulses - p0), 32'd0);
        check("abort_gp",     gp_in, 32'h0);
        check("abort_pend",   32'(pending), 32'd0);
        check("abort_go",     32'(go_pulse), 32'd0);

        // Button held through reset release, then held for auto-repeat window
        p0 = n_pulses;
        pb_go = 1'b1; rst = 1'b1;
        tick(2);
        rst = 1'b0;
        press_and_check("p4");
        tick(1);
        check("p4_gp", gp_in, 32'h2C);
        check("p4_go1", 32'(go_pulse), 32'd0);
        for (int i = 2; i <= 49; i++) begin
            tick(1);
            check($sformatf("rpt_%0d", i), 32'(go_pulse),
                  32'((c_AR && (i % 10 == 0) && (i <= 30)) ? 1 : 0));
            if (i == 29) pb_go = 1'b0;
        end
        check("rpt_total", 32'(n_pulses - p0), c_AR ? 32'd4 : 32'd1);
        check("rpt_gp",    gp_in, 32'h2C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sw_input_ctrl.md
SW_INPUT_CTRL -- requirements
Module: sw_input_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 25: consecutive stable clk cycles needed to accept a level change (5 ms at 5 kHz).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 2500: auto-repeat period in clk cycles; used only with PB_AUTOREPEAT_EN.
REQ-003 SHALL have port clk  input  1  single system clock, the same clock that drives the system and led_mux.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sw_n  input  4  raw, asynchronous operand switches.
REQ-006 SHALL have port sw_sel  input  1  raw, asynchronous display-select switch.
REQ-007 SHALL have port pb_go  input  1  raw, asynchronous pushbutton, high when pressed.
REQ-008 SHALL have port ack  input  1  level from a system GPIO output bit; clears pending.
REQ-009 SHALL have port gp_in  output  32  layout {26'b0, pending, snap_sel, snap_n[3:0]}, driven to the system GPIO input.
REQ-010 SHALL have port go_pulse  output  1  one-cycle strobe for each accepted press (or repeat).
REQ-011 SHALL have port pending  output  1  a snapshot is held and not yet acknowledged.

Function
REQ-012 SHALL pass each of the 6 raw inputs through a 2-flop synchronizer before any other logic.
REQ-013 Each synchronized bit SHALL be debounced independently by a counter.
- The count increments while the synchronized value differs from the debounced value.
- The count resets to 0 on any cycle where they match.
- The debounced value takes the synchronized value on the edge where the count reaches DEB_CYCLES-1, and the count then clears.
REQ-014 Latency from a clean raw edge to the debounced change SHALL be exactly 2+DEB_CYCLES clk edges.
REQ-015 A glitch shorter than DEB_CYCLES cycles SHALL produce no debounced change.
REQ-016 The button FSM SHALL have the states IDLE, PRESSED and RELEASE_WAIT.
- IDLE -> PRESSED on a debounced pb_go rising edge.
- PRESSED -> RELEASE_WAIT on a debounced pb_go fall.
- RELEASE_WAIT -> IDLE on the next cycle.
REQ-017 On the IDLE->PRESSED edge the block SHALL, in the same cycle:
- capture the debounced sw_sel/sw_n into snap_sel/snap_n;
- assert go_pulse for exactly one cycle;
- set pending.
REQ-018 snap_sel and snap_n SHALL change only on a press (or repeat) event.
REQ-019 Debounced sw_sel/sw_n changes outside a press SHALL NOT affect gp_in.
REQ-020 pending SHALL clear on the edge after ack is sampled high.
REQ-021 When a press event and ack coincide, the press SHALL win: pending stays 1 and the new snapshot is loaded.
REQ-022 A press while pending=1 SHALL overwrite the snapshot and re-pulse go_pulse; pending stays 1.
REQ-023 gp_in SHALL be registered, and bits [31:6] SHALL always be 0.

Reset
REQ-024 While rst=1, all of the following SHALL be 0, asynchronously:
- synchronizer flops, debounced values and debounce counters;
- snap_sel, snap_n, pending, go_pulse and gp_in.
REQ-025 While rst=1, the FSM SHALL be in IDLE.
REQ-026 If pb_go is held through reset release, it SHALL debounce from 0 and produce exactly one press after 2+DEB_CYCLES cycles.
REQ-027 Reset asserted mid-debounce or mid-press SHALL abandon the operation; no go_pulse is emitted on release.

Configuration
REQ-028 With macro PB_AUTOREPEAT_EN defined, auto-repeat SHALL be enabled.
- While in PRESSED, a repeat counter runs.
- Every REPEAT_CYCLES cycles it re-snapshots the switches, pulses go_pulse and sets pending.
- The counter clears on leaving PRESSED.
REQ-029 Without PB_AUTOREPEAT_EN, there SHALL be exactly one go_pulse per press, and no repeat counter logic is synthesized.

Structure
REQ-030 Shared package sw_input_pkg SHALL hold:
- the FSM state encodings;
- the gp_in bit positions (GPI_N_LSB=0, GPI_SEL=4, GPI_PEND=5);
- the default DEB_CYCLES and REPEAT_CYCLES.
REQ-031 Sub-module debounce_cell (synchronizer + counter, parameter DEB_CYCLES) SHALL be instantiated 6 times: 4 for sw_n, 1 for sw_sel, 1 for pb_go.

Verification (DEB_CYCLES=4, REPEAT_CYCLES=10)
REQ-032 sw_n=4'h5, sw_sel=1, clean pb_go press -> go_pulse exactly 6 cycles after the raw edge; gp_in=32'h35; pending=1.
REQ-033 pb_go toggled 1,0,1,0 with 2-cycle periods, then held low -> no go_pulse; gp_in unchanged.
REQ-034 pending=1 and ack=1 for 1 cycle -> gp_in=32'h15 the next cycle; with ack coinciding with a new press of n=4'hA -> gp_in=32'h3A.
REQ-035 Switches change to n=4'h3 with no press -> gp_in keeps its prior snapshot.
REQ-036 rst asserted 2 cycles into a press debounce, then released with pb_go low -> all outputs 0 and no go_pulse.
REQ-037 PB_AUTOREPEAT_EN defined, pb_go held for 35 cycles after the first go_pulse -> 3 additional pulses, spaced 10 cycles apart; undefined -> exactly 1 pulse.
